filter_matrix_drain: RTL and testbench

Drains one captured 6x6 filter matrix and streams its surviving entries (filter bit set, drop clear) one per cycle over a valid/ready interface, in ascending flat index order (k = row*6 + col). It sits directly downstream of the filter matrix stage in the preprocess path. It converts the wide parallel matrix into the sparse entry stream consumed by the scatter/gather dispatcher.

---
 rtl/filter_matrix_drain_pkg.sv | 46 ++++
 rtl/filter_matrix_drain_if.sv | 30 +++
 rtl/filter_matrix_drain_lsb_prio_enc36.sv | 30 +++
 rtl/filter_matrix_drain.sv | 158 +++++++++++++++
 tb/tb_filter_matrix_drain.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_matrix_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : filter_pkg
//  Description : Shared constants, state encoding and helpers for the
//                filter-matrix drain stage.
//  Revision    : 1.0  initial release
// ============================================================================
package filter_pkg;

    localparam int ROWS   = 6;
    localparam int COLS   = 6;
    localparam int W_WGT  = 5;
    localparam int W_CODE = 6;
    localparam int N_ENT  = ROWS * COLS;
    localparam int W_IDX  = 6;
    localparam int W_RC   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Flat index to {row, col}; octal digits are exactly row and column,
    // so the stream never needs a divide-by-6.
    localparam logic [2*W_RC-1:0] RC_LUT [N_ENT] = '{
        6'o00, 6'o01, 6'o02, 6'o03, 6'o04, 6'o05,
        6'o10, 6'o11, 6'o12, 6'o13, 6'o14, 6'o15,
        6'o20, 6'o21, 6'o22, 6'o23, 6'o24, 6'o25,
        6'o30, 6'o31, 6'o32, 6'o33, 6'o34, 6'o35,
        6'o40, 6'o41, 6'o42, 6'o43, 6'o44, 6'o45,
        6'o50, 6'o51, 6'o52, 6'o53, 6'o54, 6'o55
    };

    // Number of set bits in a 36-bit entry mask.
    function automatic logic [W_IDX-1:0] popcount36(input logic [N_ENT-1:0] v);
        logic [W_IDX-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_ENT; i++) begin
            cnt = cnt + W_IDX'(v[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_matrix_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : filter_matrix_drain_if
//  Description : Valid/ready entry stream from the drain stage to the
//                scatter/gather dispatcher.
//  Revision    : 1.0  initial release
// ============================================================================
interface filter_matrix_drain_if;
    import filter_pkg::*;

    logic                 out_valid;
    logic                 out_ready;
    logic [W_RC-1:0]      out_row;
    logic [W_RC-1:0]      out_col;
    logic [W_WGT-1:0]     out_weight;
    logic [W_CODE-1:0]    out_code;
    logic                 out_last;

    modport master (
        output out_valid, out_row, out_col, out_weight, out_code, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_row, out_col, out_weight, out_code, out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/filter_matrix_drain_lsb_prio_enc36.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_prio_enc36
//  Description : Lowest-set-bit priority encoder over a 36-bit vector,
//                giving the index, a found flag and the one-hot select.
//  Revision    : 1.0  initial release
// ============================================================================
module lsb_prio_enc36
    import filter_pkg::*;
(
    input  logic [N_ENT-1:0] vec,
    output logic [W_IDX-1:0] idx,
    output logic             found,
    output logic [N_ENT-1:0] onehot
);

    // Isolate the lowest set bit and scan downward so the lowest index wins.
    always_comb begin
        onehot = vec & (~vec + N_ENT'(1));
        found  = |vec;
        idx    = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W_IDX'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_matrix_drain.sv
`default_nettype none
// ============================================================================
//  Module      : filter_matrix_drain
//  Description : Captures one 6x6 filter matrix and streams its surviving
//                entries (filter set, drop clear) in ascending flat index
//                order, one per accepted handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module filter_matrix_drain
    import filter_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [N_ENT-1:0]          filter_bit,
    input  logic [N_ENT*W_WGT-1:0]    filter_weight,
    input  logic [N_ENT*W_CODE-1:0]   filter_out,
    input  logic [N_ENT-1:0]          drop,
    output logic                      busy,
    output logic                      done,
    output logic [W_IDX-1:0]          emit_count,
    output logic [W_IDX-1:0]          drop_count,
    output logic                      overrun,
    filter_matrix_drain_if.master     out_if
);

    state_t                    state_q,      state_d;
    logic [N_ENT-1:0]          pending_q,    pending_d;
    logic [N_ENT*W_WGT-1:0]    weight_q,     weight_d;
    logic [N_ENT*W_CODE-1:0]   code_q,       code_d;
    logic [W_IDX-1:0]          emit_count_q, emit_count_d;
    logic [W_IDX-1:0]          drop_count_q, drop_count_d;
    logic                      overrun_q,    overrun_d;
    logic                      busy_q;
    logic                      done_q;

    logic [W_IDX-1:0]          sel_idx;
    logic                      sel_found;
    logic [N_ENT-1:0]          sel_onehot;
    logic [2*W_RC-1:0]         sel_rc;
    logic [W_WGT-1:0]          sel_weight;
    logic [W_CODE-1:0]         sel_code;
    logic                      out_valid;
    logic                      out_last;
    logic                      accept;
    logic [N_ENT-1:0]          survivors;

    lsb_prio_enc36 u_enc (
        .vec    (pending_q),
        .idx    (sel_idx),
        .found  (sel_found),
        .onehot (sel_onehot)
    );

    // Select the captured fields of the current entry with the one-hot mask.
    always_comb begin
        sel_weight = '0;
        sel_code   = '0;
        for (int i = 0; i < N_ENT; i++) begin
            sel_weight = sel_weight | ({W_WGT{sel_onehot[i]}}  & weight_q[i*W_WGT  +: W_WGT]);
            sel_code   = sel_code   | ({W_CODE{sel_onehot[i]}} & code_q[i*W_CODE +: W_CODE]);
        end
        sel_rc = RC_LUT[sel_idx];
    end

    // Stream outputs derive only from registered state; ready never feeds valid.
    always_comb begin
        out_valid = (state_q == ST_DRAIN) && sel_found;
        out_last  = out_valid && ((pending_q & (pending_q - N_ENT'(1))) == '0);
        accept    = out_valid && out_if.out_ready;
    end

    // Next-state and datapath update for capture, drain and completion.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        weight_d     = weight_q;
        code_d       = code_q;
        emit_count_d = emit_count_q;
        drop_count_d = drop_count_q;
        overrun_d    = overrun_q;
        survivors    = filter_bit & ~drop;

        if (load && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    weight_d     = filter_weight;
                    code_d       = filter_out;
                    pending_d    = survivors;
                    drop_count_d = popcount36(filter_bit & drop);
                    emit_count_d = '0;
                    state_d      = (|survivors) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    pending_d    = pending_q & ~sel_onehot;
                    emit_count_d = emit_count_q + W_IDX'(1);
                    if (out_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and capture registers; busy/done are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            weight_q     <= '0;
            code_q       <= '0;
            emit_count_q <= '0;
            drop_count_q <= '0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            weight_q     <= weight_d;
            code_q       <= code_d;
            emit_count_q <= emit_count_d;
            drop_count_q <= drop_count_d;
            overrun_q    <= overrun_d;
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
        end
    end

    // Data fields read zero whenever no entry is presented.
    always_comb begin
        out_if.out_valid  = out_valid;
        out_if.out_last   = out_last;
        out_if.out_row    = out_valid ? sel_rc[2*W_RC-1:W_RC] : '0;
        out_if.out_col    = out_valid ? sel_rc[W_RC-1:0]      : '0;
        out_if.out_weight = out_valid ? sel_weight            : '0;
        out_if.out_code   = out_valid ? sel_code              : '0;
        busy              = busy_q;
        done              = done_q;
        emit_count        = emit_count_q;
        drop_count        = drop_count_q;
        overrun           = overrun_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_filter_matrix_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_matrix_drain
//  Description : Self-checking bench for filter_matrix_drain with a queue
//                based reference model of the surviving-entry stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_filter_matrix_drain;
    import filter_pkg::*;

    logic                    clk;
    logic                    reset;
    logic                    load;
    logic [N_ENT-1:0]        filter_bit;
    logic [N_ENT*W_WGT-1:0]  filter_weight;
    logic [N_ENT*W_CODE-1:0] filter_out;
    logic [N_ENT-1:0]        drop;
    logic                    busy;
    logic                    done;
    logic [5:0]              emit_count;
    logic [5:0]              drop_count;
    logic                    overrun;

    int total = 0;
    int bad   = 0;
    bit exp_ovr = 0;

    filter_matrix_drain_if u_if();

    filter_matrix_drain u_dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .filter_bit    (filter_bit),
        .filter_weight (filter_weight),
        .filter_out    (filter_out),
        .drop          (drop),
        .busy          (busy),
        .done          (done),
        .emit_count    (emit_count),
        .drop_count    (drop_count),
        .overrun       (overrun),
        .out_if        (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One matrix through the DUT. mode: 0 ready high, 1 random ready,
    // 2 ready low for the first 5 presented cycles. pulse_at / abort_at fire
    // when that many entries have been accepted (-1 disables).
    task automatic run_matrix(input logic [N_ENT-1:0] fb, input logic [N_ENT-1:0] dr,
                              input logic [N_ENT*W_WGT-1:0] wt, input logic [N_ENT*W_CODE-1:0] cd,
                              input int mode, input int pulse_at, input int abort_at);
        int  exp_k[$];
        int  n, ndrop, popped, stall, c, k;
        bit  seen_done, pulsed;
        logic rdy;

        exp_k.delete();
        ndrop = 0;
        for (int i = 0; i < N_ENT; i++) begin
            if (fb[i] && !dr[i]) exp_k.push_back(i);
            if (fb[i] && dr[i])  ndrop++;
        end
        n = exp_k.size();
        popped = 0; stall = 0; seen_done = 0; pulsed = 0;

        filter_bit    = fb;
        drop          = dr;
        filter_weight = wt;
        filter_out    = cd;
        load          = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        c = 1;
        check_eq("busy_after_load", 64'(busy), 64'd1);

        while (!seen_done && c < 300) begin
            if (done) begin
                seen_done = 1;
                check_eq("done_no_valid", 64'(u_if.out_valid), 64'd0);
                check_eq("done_all_emitted", 64'(exp_k.size()), 64'd0);
                check_eq("emit_count_final", 64'(emit_count), 64'(n));
                check_eq("drop_count", 64'(drop_count), 64'(ndrop));
                check_eq("overrun", 64'(overrun), 64'(exp_ovr));
                check_eq("busy_in_done", 64'(busy), 64'd1);
                if (mode == 0) check_eq("done_latency", 64'(c), 64'(n + 1));
            end else if (u_if.out_valid) begin
                if (exp_k.size() == 0) begin
                    check_eq("unexpected_entry", 64'd1, 64'd0);
                    k = 0;
                end else begin
                    k = exp_k[0];
                end
                check_eq("row",    64'(u_if.out_row),    64'(k / COLS));
                check_eq("col",    64'(u_if.out_col),    64'(k % COLS));
                check_eq("weight", 64'(u_if.out_weight), 64'(wt[k*W_WGT +: W_WGT]));
                check_eq("code",   64'(u_if.out_code),   64'(cd[k*W_CODE +: W_CODE]));
                check_eq("last",   64'(u_if.out_last),   64'(exp_k.size() == 1));
                check_eq("emit_count_run", 64'(emit_count), 64'(popped));
                check_eq("busy_drain", 64'(busy), 64'd1);

                if (abort_at == popped) begin
                    reset = 1'b0;
                    #1;
                    check_eq("rst_valid", 64'(u_if.out_valid), 64'd0);
                    check_eq("rst_busy",  64'(busy),           64'd0);
                    check_eq("rst_emit",  64'(emit_count),     64'd0);
                    check_eq("rst_ovr",   64'(overrun),        64'd0);
                    exp_ovr = 0;
                    @(posedge clk); #1;
                    reset = 1'b1;
                    return;
                end

                if (pulse_at == popped && !pulsed) begin
                    pulsed        = 1;
                    load          = 1'b1;
                    filter_bit    = ~fb;
                    drop          = '0;
                    filter_weight = ~wt;
                    filter_out    = ~cd;
                    exp_ovr       = 1;
                end

                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 2) != 0);
                    default: begin
                        rdy = (stall >= 5);
                        stall++;
                    end
                endcase
                u_if.out_ready = rdy;
                if (rdy) begin
                    popped++;
                    void'(exp_k.pop_front());
                end
            end else begin
                check_eq("valid_gap", 64'd1, 64'd0);
            end
            @(posedge clk); #1;
            load = 1'b0;
            c++;
        end

        if (!seen_done) begin
            check_eq("timeout", 64'd0, 64'd1);
        end else begin
            check_eq("done_pulse_end", 64'(done), 64'd0);
            check_eq("idle_not_busy",  64'(busy), 64'd0);
        end
        u_if.out_ready = 1'b0;
    endtask

    task automatic rand_fields(output logic [N_ENT*W_WGT-1:0] wt, output logic [N_ENT*W_CODE-1:0] cd);
        for (int i = 0; i < N_ENT; i++) begin
            wt[i*W_WGT  +: W_WGT]  = W_WGT'($urandom);
            cd[i*W_CODE +: W_CODE] = W_CODE'($urandom);
        end
    endtask

    initial begin
        logic [N_ENT-1:0]        fb, dr;
        logic [N_ENT*W_WGT-1:0]  wt;
        logic [N_ENT*W_CODE-1:0] cd;

        reset = 1'b0; load = 1'b0; u_if.out_ready = 1'b0;
        filter_bit = '0; drop = '0; filter_weight = '0; filter_out = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_valid",  64'(u_if.out_valid),  64'd0);
        check_eq("reset_last",   64'(u_if.out_last),   64'd0);
        check_eq("reset_busy",   64'(busy),            64'd0);
        check_eq("reset_done",   64'(done),            64'd0);
        check_eq("reset_emit",   64'(emit_count),      64'd0);
        check_eq("reset_drop",   64'(drop_count),      64'd0);
        check_eq("reset_ovr",    64'(overrun),         64'd0);
        check_eq("reset_weight", 64'(u_if.out_weight), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Full matrix, nothing dropped.
        rand_fields(wt, cd);
        fb = '1; dr = '0;
        run_matrix(fb, dr, wt, cd, 0, -1, -1);

        // Entries 0, 7, 35 with 7 dropped.
        rand_fields(wt, cd);
        fb = '0; dr = '0;
        fb[0] = 1'b1; fb[7] = 1'b1; fb[35] = 1'b1; dr[7] = 1'b1;
        run_matrix(fb, dr, wt, cd, 0, -1, -1);

        // Empty matrix.
        fb = '0; dr = '0;
        run_matrix(fb, dr, wt, cd, 0, -1, -1);

        // Single survivor at k=14 with a 5-cycle stall.
        rand_fields(wt, cd);
        fb = '0; fb[14] = 1'b1; dr = '0;
        run_matrix(fb, dr, wt, cd, 2, -1, -1);

        // Load pulsed at the second of four entries.
        rand_fields(wt, cd);
        fb = '0; fb[3] = 1'b1; fb[9] = 1'b1; fb[20] = 1'b1; fb[30] = 1'b1; dr = '0;
        run_matrix(fb, dr, wt, cd, 0, 1, -1);

        // Random matrices with random back-pressure.
        for (int t = 0; t < 6; t++) begin
            rand_fields(wt, cd);
            for (int i = 0; i < N_ENT; i++) begin
                fb[i] = ($urandom_range(0, 3) != 0);
                dr[i] = ($urandom_range(0, 3) == 0);
            end
            run_matrix(fb, dr, wt, cd, 1, -1, -1);
        end

        // Reset after 3 of 10 entries, then a fresh drain.
        rand_fields(wt, cd);
        fb = '0; dr = '0;
        for (int i = 0; i < 10; i++) fb[2 + 3*i] = 1'b1;
        run_matrix(fb, dr, wt, cd, 0, -1, 3);
        rand_fields(wt, cd);
        fb = '0; fb[5] = 1'b1; fb[6] = 1'b1; fb[33] = 1'b1; dr = '0; dr[6] = 1'b1;
        run_matrix(fb, dr, wt, cd, 0, -1, -1);

        for (int t = 0; t < 4; t++) begin
            rand_fields(wt, cd);
            for (int i = 0; i < N_ENT; i++) begin
                fb[i] = ($urandom_range(0, 1) != 0);
                dr[i] = ($urandom_range(0, 4) == 0);
            end
            run_matrix(fb, dr, wt, cd, (t % 2), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
